vx_commit_arb: RTL and testbench

- Parametrised N-to-1 commit merger for one issue slot of the execute stage.
- Merges commit streams from NUM_UNITS execution units (ALU, LSU, FPU, SFU and any future units) into one writeback stream.
- Supports round-robin or fixed-priority arbitration.
- A multi-packet commit (e.g. a split LSU response) is kept contiguous through an end-of-packet (eop) grant lock.
- Optional registered output and per-unit commit counters for perf.

---
 rtl/vx_commit_arb_pkg.sv | 22 ++
 rtl/vx_commit_skid.sv | 56 +++++
 rtl/vx_commit_arb.sv | 145 ++++++++++++++
 tb/tb_vx_commit_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_arb_pkg.sv
// Shared definitions for the commit merger: arbitration modes, commit payload layout
// and a helper that sizes unit-index fields.
package vx_commit_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic [7:0]  wid;
    logic [7:0]  rd;
    logic [15:0] tmask;
    logic [31:0] pc;
  } commit_t;

  localparam int COMMIT_W = $bits(commit_t);

  // Unit-index width; a single unit still gets a 1-bit index.
  function automatic int unit_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_skid.sv
// Two-entry output skid FIFO; full is registered so upstream ready never sees
// a combinational path from the downstream ready.
module vx_commit_skid
  import vx_commit_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         full_reg;
  logic         pop;

  assign pop_valid = (count_reg != 2'd0);
  assign pop_data  = mem_reg[rd_ptr_reg];
  assign pop       = pop_valid && pop_ready;
  assign full      = full_reg;

  always_comb begin
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      full_reg   <= 1'b0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == 2'd2);
    end
  end

endmodule

// File: rtl/vx_commit_arb.sv
// N-to-1 commit merger: round-robin or fixed-priority grant, eop grant lock,
// optional skid-buffered output and per-unit commit counters.
module vx_commit_arb
  import vx_commit_arb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int DATAW     = COMMIT_W,
  parameter int ARB_MODE  = ARB_RR,
  parameter int OUT_BUF   = 1,
  parameter int CTR_W     = 32,
  localparam int UNITW    = unit_w(NUM_UNITS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_UNITS-1:0]       in_valid,
  input  logic [NUM_UNITS*DATAW-1:0] in_data,
  input  logic [NUM_UNITS-1:0]       in_eop,
  output logic [NUM_UNITS-1:0]       in_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic [UNITW-1:0]           out_unit,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic [NUM_UNITS*CTR_W-1:0] commit_cnt
);

  logic [NUM_UNITS-1:0] grant;
  logic                 sel_valid;
  logic [UNITW-1:0]     sel_idx;
  logic                 sel_eop;
  logic [DATAW-1:0]     sel_data;
  logic                 sink_ready;
  logic                 accept;
  logic                 lock_valid_reg;
  logic [UNITW-1:0]     lock_unit_reg;
  logic [UNITW-1:0]     rr_ptr_reg;

  // A unit's grant is derived only from the other units' requests, so at most
  // one valid&&ready pair exists and in_ready never loops back on its own valid.
  always_comb begin
    logic blocked;
    logic hit;
    int   u;
    grant   = '0;
    blocked = 1'b0;
    hit     = 1'b0;
    u       = 0;
    if (lock_valid_reg) begin
      for (int g = 0; g < NUM_UNITS; g++) begin
        grant[g] = (lock_unit_reg == UNITW'(g));
      end
    end else if (ARB_MODE == ARB_FIXED) begin
      for (int g = 0; g < NUM_UNITS; g++) begin
        grant[g] = !blocked;
        blocked  = blocked | in_valid[g];
      end
    end else begin
      for (int g = 0; g < NUM_UNITS; g++) begin
        blocked = 1'b0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
          u = (int'(rr_ptr_reg) + k) % NUM_UNITS;
          if (u == g) begin
            hit = 1'b1;
          end else if (!hit && in_valid[u]) begin
            blocked = 1'b1;
          end
        end
        grant[g] = !blocked;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int g = 0; g < NUM_UNITS; g++) begin
      if (grant[g] && in_valid[g]) begin
        sel_valid = 1'b1;
        sel_idx   = UNITW'(g);
        sel_eop   = in_eop[g];
        sel_data  = in_data[g*DATAW +: DATAW];
      end
    end
  end

  assign accept   = sel_valid && sink_ready && !reset;
  assign in_ready = grant & {NUM_UNITS{sink_ready && !reset}};

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_reg <= 1'b0;
      lock_unit_reg  <= '0;
      rr_ptr_reg     <= '0;
    end else if (accept) begin
      lock_valid_reg <= !sel_eop;
      lock_unit_reg  <= sel_idx;
      if (sel_eop) begin
        rr_ptr_reg <= (sel_idx == UNITW'(NUM_UNITS - 1)) ? '0 : sel_idx + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_cnt
    logic [CTR_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (accept && (sel_idx == UNITW'(gi))) begin
        cnt_reg <= cnt_reg + CTR_W'(1);
      end
    end
    assign commit_cnt[gi*CTR_W +: CTR_W] = cnt_reg;
  end

  if (OUT_BUF != 0) begin : g_skid
    logic skid_full;
    logic [DATAW+UNITW:0] skid_data;

    vx_commit_skid #(
      .W (DATAW + UNITW + 1)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data ({sel_data, sel_idx, sel_eop}),
      .full      (skid_full),
      .pop_ready (out_ready),
      .pop_valid (out_valid),
      .pop_data  (skid_data)
    );

    assign sink_ready = !skid_full;
    assign {out_data, out_unit, out_eop} = skid_data;
  end else begin : g_comb
    assign sink_ready = out_ready;
    assign out_valid  = sel_valid && !reset;
    assign out_data   = reset ? '0 : sel_data;
    assign out_unit   = reset ? '0 : sel_idx;
    assign out_eop    = sel_eop && !reset;
  end

endmodule

// File: tb/tb_vx_commit_arb.sv
// Randomized scoreboard bench: four DUT configurations run side by side, each
// against a queue-based reference model of the arbitration and buffering rules.
module tb_vx_commit_arb;
  import vx_commit_arb_pkg::*;

  localparam int DW    = COMMIT_W;
  localparam int NCFG  = 4;
  localparam int TOTAL = 4000;
  localparam int DRAIN = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic int cfg_n(input int i);
    case (i) 0: return 4; 1: return 4; 2: return 3; default: return 1; endcase
  endfunction
  function automatic int cfg_mode(input int i);
    return (i == 1) ? ARB_FIXED : ARB_RR;
  endfunction
  function automatic int cfg_ob(input int i);
    case (i) 0: return 1; 1: return 0; 2: return 0; default: return 1; endcase
  endfunction
  function automatic int cfg_cw(input int i);
    case (i) 0: return 4; 1: return 32; 2: return 3; default: return 8; endcase
  endfunction
  function automatic bit in_reset(input int c);
    return (c < 3) || (c == 1500) || (c >= 2700 && c < 2702);
  endfunction

  task automatic check(input bit ok, input string name, input int cfg,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h", name, cfg, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int N    = cfg_n(gi);
    localparam int MODE = cfg_mode(gi);
    localparam int OB   = cfg_ob(gi);
    localparam int CW   = cfg_cw(gi);
    localparam int UW   = unit_w(N);

    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_eop = '0;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [UW-1:0]   out_unit;
    logic            out_eop;
    logic            out_ready = 1'b0;
    logic [N*CW-1:0] commit_cnt;

    vx_commit_arb #(
      .NUM_UNITS (N),
      .DATAW     (DW),
      .ARB_MODE  (MODE),
      .OUT_BUF   (OB),
      .CTR_W     (CW)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_eop     (in_eop),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_unit   (out_unit),
      .out_eop    (out_eop),
      .out_ready  (out_ready),
      .commit_cnt (commit_cnt)
    );

    int            lock_u = -1;
    int            rr = 0;
    int            occ = 0;
    int            acc_u = -1;
    int            cnt [N];
    logic [DW-1:0] q_data [$];
    int            q_unit [$];
    bit            q_eop [$];

    // Upstream units: hold a packet until accepted, otherwise offer a new random one.
    initial begin
      int phase;
      forever begin
        @(posedge clk);
        #2;
        phase = (cyc / 150) % 4;
        case (phase)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = ($urandom_range(0, 9) == 0);
          default: out_ready = ($urandom_range(0, 9) != 0);
        endcase
        if (cyc >= TOTAL - DRAIN) out_ready = 1'b1;
        for (int u = 0; u < N; u++) begin
          if (reset) begin
            in_valid[u] = 1'b0;
          end else if (in_valid[u] && acc_u != u) begin
            in_valid[u] = 1'b1;
          end else if (cyc >= TOTAL - DRAIN) begin
            in_valid[u] = 1'b0;
          end else begin
            in_valid[u] = ($urandom_range(0, 3) != 0);
            in_eop[u]   = ($urandom_range(0, 2) != 0);
            in_data[u*DW +: DW] = DW'({$urandom(), $urandom()});
          end
        end
      end
    end

    // Reference model: decides the winner, checks readiness and counters, queues expectations.
    initial begin
      int            w;
      bit            sink;
      bit            pop;
      logic [N-1:0]  exp_rdy;
      logic [CW-1:0] exp_c;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      forever begin
        @(negedge clk);
        acc_u = -1;
        if (reset) begin
          check(in_ready == '0, "reset_in_ready", gi, 128'(in_ready), 128'(0));
          lock_u = -1;
          rr     = 0;
          occ    = 0;
          for (int i = 0; i < N; i++) cnt[i] = 0;
          q_data.delete();
          q_unit.delete();
          q_eop.delete();
        end else begin
          for (int i = 0; i < N; i++) begin
            exp_c = CW'(cnt[i]);
            check(commit_cnt[i*CW +: CW] == exp_c, "commit_cnt", gi,
                  128'(commit_cnt[i*CW +: CW]), 128'(exp_c));
          end
          w = -1;
          if (lock_u >= 0) begin
            if (in_valid[lock_u]) w = lock_u;
          end else if (MODE == ARB_FIXED) begin
            for (int k = N - 1; k >= 0; k--) if (in_valid[k]) w = k;
          end else begin
            for (int k = N - 1; k >= 0; k--) if (in_valid[(rr + k) % N]) w = (rr + k) % N;
          end
          sink = (OB != 0) ? (occ < 2) : out_ready;
          if (OB != 0) begin
            check(out_valid == (occ > 0), "out_valid", gi, 128'(out_valid), 128'(occ > 0));
          end else begin
            check(out_valid == (w >= 0), "out_valid", gi, 128'(out_valid), 128'(w >= 0));
          end
          exp_rdy = '0;
          if (w >= 0 && sink) exp_rdy[w] = 1'b1;
          check((in_ready & in_valid) == exp_rdy, "in_ready", gi,
                128'(in_ready & in_valid), 128'(exp_rdy));
          pop = (occ > 0) && out_ready;
          if (w >= 0 && sink) begin
            acc_u = w;
            q_data.push_back(in_data[w*DW +: DW]);
            q_unit.push_back(w);
            q_eop.push_back(in_eop[w]);
            cnt[w]++;
            if (in_eop[w]) begin
              lock_u = -1;
              rr     = (w + 1) % N;
            end else begin
              lock_u = w;
            end
          end
          if (OB != 0) occ = occ + ((acc_u >= 0) ? 1 : 0) - (pop ? 1 : 0);
        end
        if (cyc == TOTAL - 1) begin
          check(q_data.size() == 0, "drained", gi, 128'(q_data.size()), 128'(0));
        end
      end
    end

    // Monitor: every delivered packet must match the oldest expected one.
    initial begin
      logic [DW-1:0] d;
      int            u;
      bit            e;
      forever begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready) begin
          if (q_data.size() == 0) begin
            check(1'b0, "unexpected_out", gi, 128'(out_data), 128'(0));
          end else begin
            d = q_data.pop_front();
            u = q_unit.pop_front();
            e = q_eop.pop_front();
            check({out_data, 32'(out_unit), 32'(out_eop)} == {d, 32'(u), 32'(e)},
                  "out_pkt", gi, {out_data, 32'(out_unit), 32'(out_eop)},
                  {d, 32'(u), 32'(e)});
          end
        end
      end
    end
  end

  initial begin
    reset = in_reset(0);
    repeat (TOTAL) begin
      @(posedge clk);
      #1;
      cyc++;
      reset = in_reset(cyc);
    end
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
